nes_controller_reader: RTL and testbench
========================================

// Module: nes_controller_reader
// PURPOSE
//  Polls a serial NES-style gamepad and produces the debounced 5-bit button word for the CPU controller_in port.
//  Sits upstream of game_Inputs: a latch/pulse shift sequence runs on a fixed poll period, and button state
//  changes only after DEBOUNCE identical consecutive frames. The raw 8-bit frame is also exported for debug LEDs.
// PARAMETERS
//  POLL_DIV     833333  clk cycles between poll starts (60 Hz at 50 MHz); must exceed 17*HALF_PERIOD+4
//  HALF_PERIOD  300     clk cycles per latch/pulse half-period (6 us at 50 MHz); >=1
//  DEBOUNCE     2       consecutive identical frames required before buttons updates; 1..15
// PORTS
//  clk          in   1  system clock
//  reset        in   1  synchronous, active-high reset
//  ctrl_data    in   1  serial data from pad, active-low (0 = pressed), externally pulled up
//  ctrl_latch   out  1  pad latch strobe, active-high
//  ctrl_pulse   out  1  pad shift clock, active-high
//  raw_buttons  out  8  last frame, 1 = pressed; [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//  buttons      out  5  debounced {A,Up,Down,Left,Right} -> CPU controller_in[4:0]
//  frame_done   out  1  one-cycle strobe, one per completed frame
// BEHAVIOUR
//  Reset: ctrl_latch=0, ctrl_pulse=0, raw_buttons=0, buttons=0, frame_done=0, FSM=IDLE,
//   poll counter=0, bit index=0, match count=0, shift reg=0. Reset mid-frame aborts immediately; no partial update.
//  Poll timer: counts 0..POLL_DIV-1 then wraps; tick on the cycle counter==POLL_DIV-1.
//   Tick in IDLE -> LATCH next cycle. Tick in any other state is dropped (no queuing).
//  FSM states/transitions (each timed state uses one shared down-counter):
//   IDLE   : latch=0, pulse=0; waits for tick.
//   LATCH  : latch=1 for 2*HALF_PERIOD cycles -> SAMPLE, bit index=0.
//   SAMPLE : latch=0, pulse=0 for HALF_PERIOD cycles; on last cycle shift[idx] <= ~ctrl_data.
//            idx==7 -> DONE, else -> PULSE.
//   PULSE  : pulse=1 for HALF_PERIOD cycles, idx++ on exit -> SAMPLE.
//   DONE   : single cycle; frame_done=1; raw_buttons <= shift; debounce update; -> IDLE.
//  Frame = 2*HP latch + 8*HP sample + 7*HP pulse + 1 cycle; exactly 1 latch and 7 pulses per frame.
//  ctrl_latch and ctrl_pulse are registered outputs, never high together, glitch-free.
//  Debounce (evaluated in DONE, against the 8-bit shift):
//   shift == previous frame -> match count++ (saturates at DEBOUNCE); else match count = 1.
//   When match count reaches DEBOUNCE (incl. DEBOUNCE=1), buttons <= {s[0],s[4],s[5],s[6],s[7]} same cycle.
//   buttons updates at the end of the DONE cycle, i.e. visible the cycle after frame_done.
//   raw_buttons updates every frame, undebounced.
//  Disconnected pad (ctrl_data stuck 1) reads all-released; buttons decays to 0 after DEBOUNCE frames.
// TESTING  (bench params: POLL_DIV=100, HALF_PERIOD=2, DEBOUNCE=2)
//  1 Reset held 5 cycles, release -> all outputs 0; latch rises on cycle 100 after release, high exactly 4 cycles.
//  2 Pad model, no press -> per frame 7 pulses of 2 cycles, 1 frame_done, raw=0x00, buttons=0.
//  3 A held low from frame 1 -> after frame 1 raw=0x01, buttons=0; after frame 2 buttons=5'b10000.
//  4 Right pressed for one frame only, released before and after -> raw shows 0x80 once, buttons stays 0.
//  5 All eight pressed for 2 frames -> raw=0xFF, buttons=5'b11111; then release for 2 frames -> buttons=0.
//  6 Reset asserted during 3rd PULSE with A held -> next cycle latch=pulse=0, buttons=0, no frame_done;
//    next latch 100 cycles after release; A visible on buttons after 2 further frames.

Source files
------------

// File: rtl/nes_controller_reader.sv
// ---------------------------------------------------------------------------
// nes_controller_reader
//
// Polls a serial NES-style gamepad on a fixed period and produces a
// debounced 5-bit button word for the CPU controller_in port. Each poll runs
// one latch strobe followed by eight samples separated by seven shift pulses.
// The debounced word only changes after DEBOUNCE identical consecutive frames.
// The raw 8-bit frame is exported every frame for debug LEDs.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  synchronous, active-high reset
//   ctrl_data    in   1  serial pad data, active-low (0 = pressed)
//   ctrl_latch   out  1  pad latch strobe, active-high, registered
//   ctrl_pulse   out  1  pad shift clock, active-high, registered
//   raw_buttons  out  8  last frame, 1 = pressed
//                        [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   buttons      out  5  debounced {A, Up, Down, Left, Right}
//   frame_done   out  1  one-cycle strobe per completed frame
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module nes_controller_reader #(
    parameter int POLL_DIV    = 833333,
    parameter int HALF_PERIOD = 300,
    parameter int DEBOUNCE    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ctrl_data,
    output logic       ctrl_latch,
    output logic       ctrl_pulse,
    output logic [7:0] raw_buttons,
    output logic [4:0] buttons,
    output logic       frame_done
);

    localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int TW = $clog2(2 * HALF_PERIOD + 1);

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_DIV - 1);
    localparam logic [TW-1:0] LATCH_LAST = TW'(2 * HALF_PERIOD - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_PERIOD - 1);
    localparam logic [3:0]    DEB_TARGET = 4'(DEBOUNCE);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE,
        PULSE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   poll_cnt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_idx_next;
    logic            sample_now;
    logic [7:0]      shift_reg;
    logic [3:0]      match_cnt;
    logic [3:0]      match_next;
    logic            buttons_load;
    logic            poll_tick;
    logic [1:0]      data_sync;

    assign poll_tick = (poll_cnt == POLL_LAST);

    // ------------------------------------------------------------------
    // State register and shared down-counter
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_next;
            timer   <= timer_next;
            bit_idx <= bit_idx_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Each timed state loads the counter with its
    // duration minus one on entry and leaves when it reaches zero.
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        timer_next   = timer;
        bit_idx_next = bit_idx;
        sample_now   = 1'b0;

        case (state)
            IDLE: begin
                // A tick arriving in any other state is simply dropped.
                if (poll_tick) begin
                    state_next = LATCH;
                    timer_next = LATCH_LAST;
                end
            end
            LATCH: begin
                if (timer == '0) begin
                    state_next   = SAMPLE;
                    timer_next   = HALF_LAST;
                    bit_idx_next = 3'd0;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            SAMPLE: begin
                if (timer == '0) begin
                    sample_now = 1'b1;
                    timer_next = HALF_LAST;
                    state_next = (bit_idx == 3'd7) ? DONE : PULSE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            PULSE: begin
                if (timer == '0) begin
                    state_next   = SAMPLE;
                    timer_next   = HALF_LAST;
                    bit_idx_next = bit_idx + 3'd1;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Debounce: count consecutive identical frames, saturating at the
    // target. raw_buttons still holds the previous frame while in DONE.
    // ------------------------------------------------------------------
    always_comb begin
        match_next = 4'd1;
        if (shift_reg == raw_buttons) begin
            match_next = (match_cnt < DEB_TARGET) ? match_cnt + 4'd1 : match_cnt;
        end
    end

    assign buttons_load = (match_next == DEB_TARGET);

    // ------------------------------------------------------------------
    // Datapath: poll timer, input synchroniser, shift register, outputs.
    // Strobes are decoded from the next state so they come straight off
    // flops and stay aligned with the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            poll_cnt    <= '0;
            data_sync   <= 2'b11;
            shift_reg   <= '0;
            match_cnt   <= '0;
            raw_buttons <= '0;
            buttons     <= '0;
            ctrl_latch  <= 1'b0;
            ctrl_pulse  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            poll_cnt <= poll_tick ? '0 : poll_cnt + 1'b1;

            // The pad line is asynchronous to clk; it is stable for at
            // least a half-period before it is sampled, so two flops of
            // delay do not disturb the read.
            data_sync <= {data_sync[0], ctrl_data};

            if (sample_now) begin
                shift_reg[bit_idx] <= ~data_sync[1];
            end

            ctrl_latch <= (state_next == LATCH);
            ctrl_pulse <= (state_next == PULSE);
            frame_done <= (state_next == DONE);

            if (state == DONE) begin
                raw_buttons <= shift_reg;
                match_cnt   <= match_next;
                if (buttons_load) begin
                    buttons <= {shift_reg[0], shift_reg[4], shift_reg[5],
                                shift_reg[6], shift_reg[7]};
                end
            end
        end
    end

endmodule

// File: tb/tb_nes_controller_reader.sv
// ---------------------------------------------------------------------------
// tb_nes_controller_reader
//
// Self-checking bench for nes_controller_reader. A behavioural gamepad model
// drives ctrl_data from a pressed-button byte, resetting its bit pointer on
// the latch and advancing it on each shift pulse. A frame-history model
// predicts raw_buttons and the debounced word.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nes_controller_reader;

    localparam int POLL_DIV    = 100;
    localparam int HALF_PERIOD = 2;
    localparam int DEBOUNCE    = 2;

    logic       clk;
    logic       reset;
    logic       ctrl_data;
    logic       ctrl_latch;
    logic       ctrl_pulse;
    logic [7:0] raw_buttons;
    logic [4:0] buttons;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    nes_controller_reader #(
        .POLL_DIV    (POLL_DIV),
        .HALF_PERIOD (HALF_PERIOD),
        .DEBOUNCE    (DEBOUNCE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl_data   (ctrl_data),
        .ctrl_latch  (ctrl_latch),
        .ctrl_pulse  (ctrl_pulse),
        .raw_buttons (raw_buttons),
        .buttons     (buttons),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- gamepad model ----------------
    logic [7:0] pad_buttons;
    logic       pad_connected;
    int         pad_idx;

    initial pad_idx = 0;
    always @(posedge ctrl_latch) pad_idx = 0;
    always @(posedge ctrl_pulse) pad_idx = pad_idx + 1;

    assign ctrl_data = !pad_connected ? 1'b1 :
                       (pad_idx < 8)  ? ~pad_buttons[pad_idx[2:0]] : 1'b1;

    // ---------------- reference model ----------------
    // Button word is taken from the newest frame once it has been seen in
    // DEBOUNCE consecutive frames since reset; otherwise it holds.
    logic [7:0] m_last;
    int         m_run;
    logic [4:0] m_buttons;

    task automatic model_reset();
        m_last    = 8'h00;
        m_run     = 0;
        m_buttons = 5'b00000;
    endtask

    task automatic model_frame(input logic [7:0] f);
        if (m_run > 0 && f == m_last) m_run = m_run + 1;
        else                          m_run = 1;
        m_last = f;
        if (m_run >= DEBOUNCE) m_buttons = {f[0], f[4], f[5], f[6], f[7]};
    endtask

    // Runs one poll frame with the given pad state and checks its waveform
    // and results. latch_at is the cycle (counted from the call) on which
    // the latch was first seen high.
    task automatic run_frame(input logic [7:0] pressed, input string tag,
                             output int latch_at);
        int         latch_rises = 0;
        int         latch_hi    = 0;
        int         pulse_rises = 0;
        int         pulse_hi    = 0;
        int         overlap     = 0;
        bit         seen_done   = 0;
        logic       prev_latch;
        logic       prev_pulse;
        logic [7:0] eff;
        logic [4:0] btn_before;

        pad_buttons = pressed;
        eff         = pad_connected ? pressed : 8'h00;
        btn_before  = m_buttons;
        prev_latch  = ctrl_latch;
        prev_pulse  = ctrl_pulse;
        latch_at    = -1;

        for (int cyc = 1; cyc <= 300 && !seen_done; cyc++) begin
            @(negedge clk);
            if (ctrl_latch && !prev_latch) begin
                latch_rises++;
                if (latch_at < 0) latch_at = cyc;
            end
            if (ctrl_pulse && !prev_pulse) pulse_rises++;
            if (ctrl_latch) latch_hi++;
            if (ctrl_pulse) pulse_hi++;
            if (ctrl_latch && ctrl_pulse) overlap++;
            prev_latch = ctrl_latch;
            prev_pulse = ctrl_pulse;
            if (frame_done) seen_done = 1;
        end

        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s frame_done_timeout: no frame_done within 300 cycles", tag);
            return;
        end

        checks++;
        if (buttons !== btn_before) begin
            errors++;
            $display("FAIL %s buttons_during_done: got %b expected %b", tag, buttons, btn_before);
        end

        model_frame(eff);
        @(negedge clk);

        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s frame_done_width: got %b expected 0", tag, frame_done);
        end
        checks++;
        if (raw_buttons !== eff) begin
            errors++;
            $display("FAIL %s raw_buttons: got %h expected %h", tag, raw_buttons, eff);
        end
        checks++;
        if (buttons !== m_buttons) begin
            errors++;
            $display("FAIL %s buttons: got %b expected %b", tag, buttons, m_buttons);
        end
        checks++;
        if (latch_rises != 1 || latch_hi != 2 * HALF_PERIOD) begin
            errors++;
            $display("FAIL %s latch_shape: got %0d rises/%0d high expected 1/%0d",
                     tag, latch_rises, latch_hi, 2 * HALF_PERIOD);
        end
        checks++;
        if (pulse_rises != 7 || pulse_hi != 7 * HALF_PERIOD) begin
            errors++;
            $display("FAIL %s pulse_shape: got %0d rises/%0d high expected 7/%0d",
                     tag, pulse_rises, pulse_hi, 7 * HALF_PERIOD);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL %s latch_pulse_overlap: got %0d cycles expected 0", tag, overlap);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int latch_at;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({ctrl_latch, ctrl_pulse, raw_buttons, buttons, frame_done} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got latch=%b pulse=%b raw=%h btn=%b done=%b expected all 0",
                     ctrl_latch, ctrl_pulse, raw_buttons, buttons, frame_done);
        end
        reset = 1'b0;
        model_reset();
        run_frame(8'h00, "reset_first", latch_at);
        checks++;
        if (latch_at != POLL_DIV) begin
            errors++;
            $display("FAIL reset_latch_delay: got cycle %0d expected %0d", latch_at, POLL_DIV);
        end
    endtask

    task automatic test_no_press();
        int latch_at;
        repeat (2) run_frame(8'h00, "no_press", latch_at);
        checks++;
        if (buttons !== 5'b00000) begin
            errors++;
            $display("FAIL no_press_buttons: got %b expected 00000", buttons);
        end
    endtask

    task automatic test_a_held();
        int latch_at;
        run_frame(8'h01, "a_held_1", latch_at);
        checks++;
        if (raw_buttons !== 8'h01 || buttons !== 5'b00000) begin
            errors++;
            $display("FAIL a_held_first: got raw=%h btn=%b expected 01/00000", raw_buttons, buttons);
        end
        run_frame(8'h01, "a_held_2", latch_at);
        checks++;
        if (buttons !== 5'b10000) begin
            errors++;
            $display("FAIL a_held_second: got %b expected 10000", buttons);
        end
    endtask

    task automatic test_single_press();
        int latch_at;
        repeat (2) run_frame(8'h00, "single_pre", latch_at);
        run_frame(8'h80, "single_right", latch_at);
        checks++;
        if (raw_buttons !== 8'h80 || buttons !== 5'b00000) begin
            errors++;
            $display("FAIL single_press_frame: got raw=%h btn=%b expected 80/00000", raw_buttons, buttons);
        end
        run_frame(8'h00, "single_post", latch_at);
        checks++;
        if (buttons !== 5'b00000) begin
            errors++;
            $display("FAIL single_press_after: got %b expected 00000", buttons);
        end
    endtask

    task automatic test_all_pressed();
        int latch_at;
        repeat (2) run_frame(8'hFF, "all_pressed", latch_at);
        checks++;
        if (raw_buttons !== 8'hFF || buttons !== 5'b11111) begin
            errors++;
            $display("FAIL all_pressed: got raw=%h btn=%b expected ff/11111", raw_buttons, buttons);
        end
        repeat (2) run_frame(8'h00, "all_released", latch_at);
        checks++;
        if (buttons !== 5'b00000) begin
            errors++;
            $display("FAIL all_released: got %b expected 00000", buttons);
        end
    endtask

    task automatic test_random();
        int         latch_at;
        logic [7:0] f;
        f = 8'h00;
        for (int i = 0; i < 12; i++) begin
            // Repeat the previous frame often so debounce completions occur.
            if ($urandom_range(0, 2) == 0) f = 8'($urandom);
            run_frame(f, "random", latch_at);
        end
    endtask

    task automatic test_disconnect();
        int latch_at;
        repeat (2) run_frame(8'hFF, "disc_pre", latch_at);
        pad_connected = 1'b0;
        repeat (2) run_frame(8'hFF, "disconnected", latch_at);
        checks++;
        if (buttons !== 5'b00000 || raw_buttons !== 8'h00) begin
            errors++;
            $display("FAIL disconnect: got raw=%h btn=%b expected 00/00000", raw_buttons, buttons);
        end
        pad_connected = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int   latch_at;
        int   rises = 0;
        int   stray_done = 0;
        logic prev_pulse;

        repeat (2) run_frame(8'h01, "mid_pre", latch_at);
        prev_pulse = ctrl_pulse;
        for (int cyc = 0; cyc < 300 && rises < 3; cyc++) begin
            @(negedge clk);
            if (ctrl_pulse && !prev_pulse) rises++;
            prev_pulse = ctrl_pulse;
        end
        checks++;
        if (rises != 3) begin
            errors++;
            $display("FAIL mid_reset_pulse_timeout: got %0d pulses expected 3", rises);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ctrl_latch, ctrl_pulse, buttons, frame_done} !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_outputs: got latch=%b pulse=%b btn=%b done=%b expected all 0",
                     ctrl_latch, ctrl_pulse, buttons, frame_done);
        end
        repeat (3) begin
            @(negedge clk);
            if (frame_done) stray_done++;
        end
        checks++;
        if (stray_done != 0) begin
            errors++;
            $display("FAIL mid_reset_frame_done: got %0d strobes expected 0", stray_done);
        end
        reset = 1'b0;
        model_reset();
        run_frame(8'h01, "mid_post_1", latch_at);
        checks++;
        if (latch_at != POLL_DIV || buttons !== 5'b00000) begin
            errors++;
            $display("FAIL mid_reset_restart: got latch cycle %0d btn=%b expected %0d/00000",
                     latch_at, buttons, POLL_DIV);
        end
        run_frame(8'h01, "mid_post_2", latch_at);
        checks++;
        if (buttons !== 5'b10000) begin
            errors++;
            $display("FAIL mid_reset_a_visible: got %b expected 10000", buttons);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        pad_connected = 1'b1;
        pad_buttons   = 8'h00;
        model_reset();

        test_reset();
        test_no_press();
        test_a_held();
        test_single_press();
        test_all_pressed();
        test_random();
        test_disconnect();
        test_reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
